// File: rtl/fifo_pkg.sv
// Shared types and defaults for the async FIFO and its read-side drainer.
// Imported by the FIFO read-side consumer logic.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    typedef logic [DEF_DATA_W-1:0] valores_t;
    typedef logic                  push_t;
    typedef logic                  pop_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } drn_state_t;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Ordered register buffer between the FIFO read port and the output stream.
// Entry 0 is the head; reads shift the remaining entries down by one.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 3
) (
    input  logic                        rdclk,
    input  logic                        rd_rst,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0]  occ
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] shifted [DEPTH];
    logic [OCC_W-1:0]  wr_idx;
    logic              do_rd;
    logic              do_wr;

    assign do_rd  = rd_en && (occ != '0);
    assign do_wr  = wr_en && ((occ != OCC_W'(DEPTH)) || do_rd);
    assign wr_idx = do_rd ? (occ - 1'b1) : occ;
    assign head   = mem[0];

    // Contents as they would look after popping the head.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            shifted[i] = mem[i + 1];
        end
        shifted[DEPTH-1] = mem[DEPTH-1];
    end

    // Storage: a write lands just behind the last live entry.
    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_wr && (wr_idx == OCC_W'(i))) begin
                    mem[i] <= wr_data;
                end else if (do_rd) begin
                    mem[i] <= shifted[i];
                end
            end
        end
    end

    // Occupancy: simultaneous write and read leaves it unchanged.
    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            occ <= '0;
        end else begin
            occ <= occ + OCC_W'(do_wr) - OCC_W'(do_rd);
        end
    end

endmodule

// File: rtl/fifo_rd_drainer.sv
// Read-domain burst consumer: pops len words from the aFIFO and streams
// them out through a skid buffer, absorbing the one-cycle read latency.
module fifo_rd_drainer
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int BUF_DEPTH = 3
) (
    input  logic              rdclk,
    input  logic              rd_rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              empty,
    input  logic [DATA_W-1:0] data_out,
    output pop_t              pop,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  rd_count
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_READ  = READ;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [OCC_W:0] DEPTH_L = (OCC_W + 1)'(BUF_DEPTH);

    logic [1:0]       state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] cnt_nxt;
    logic             inflight;
    logic             xfer;
    logic             accept;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   used;

    // Slots already claimed: buffered words plus the one on the read bus.
    assign used    = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    assign pop     = (state == ST_READ) && !empty &&
                     (issued < len_q) && (used < DEPTH_L);
    assign m_valid = (occ != '0);
    assign xfer    = m_valid && m_ready;
    assign cnt_nxt = rd_count + CNT_W'(xfer);
    assign accept  = (state == ST_IDLE) && start && (len != '0);
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

    // Burst sequencing: issue pops, then wait for the last accept.
    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            state  <= ST_IDLE;
            len_q  <= '0;
            issued <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        len_q  <= len;
                        issued <= '0;
                        state  <= ST_READ;
                    end else if (start) begin
                        state  <= ST_DONE;
                    end
                end
                ST_READ: begin
                    if (pop) begin
                        issued <= issued + CNT_W'(1);
                        if ((issued + CNT_W'(1)) == len_q) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt_nxt == len_q) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read latency tracking and downstream accept counting.
    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            inflight <= 1'b0;
            rd_count <= '0;
        end else begin
            inflight <= pop;
            if (accept) begin
                rd_count <= '0;
            end else if (xfer) begin
                rd_count <= cnt_nxt;
            end
        end
    end

    fifo_rd_skid_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_skid (
        .rdclk   (rdclk),
        .rd_rst  (rd_rst),
        .wr_en   (inflight),
        .wr_data (data_out),
        .rd_en   (xfer),
        .head    (m_data),
        .occ     (occ)
    );

endmodule

// File: tb/tb_fifo_rd_drainer.sv
// Bench for fifo_rd_drainer: queue-based FIFO model, ordered-stream
// scoreboard, table-driven bursts, corner sequences and random bursts.
module tb_fifo_rd_drainer;

    logic       rdclk = 1'b0;
    logic       rd_rst;
    logic       start;
    logic [7:0] len;
    logic       empty = 1'b1;
    logic [7:0] data_out = 8'h00;
    logic       pop;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic       busy;
    logic       done;
    logic [7:0] rd_count;

    logic       push_en;
    logic       flush;
    logic [7:0] push_val;

    logic [7:0] fq[$];
    logic [7:0] expq[$];
    logic [7:0] pend[$];

    int errors = 0;
    int checks = 0;

    int         cyc = 0;
    int         pops = 0;
    int         done_cnt = 0;
    int         stab_errs = 0;
    int         pe_errs = 0;
    int         pop_cyc[$];
    logic [7:0] got[$];
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;

    typedef struct {
        int len;
        int base;
        int rmode;
        int exp_cnt;
        int exp_last;
    } vec_t;

    vec_t vecs[4];

    always #5 rdclk = ~rdclk;

    fifo_rd_drainer dut (
        .rdclk    (rdclk),
        .rd_rst   (rd_rst),
        .start    (start),
        .len      (len),
        .empty    (empty),
        .data_out (data_out),
        .pop      (pop),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .busy     (busy),
        .done     (done),
        .rd_count (rd_count)
    );

    // FIFO read port model: data one cycle after pop, registered empty.
    always @(posedge rdclk) begin
        if (flush) begin
            fq.delete();
        end else begin
            if (pop && fq.size() > 0) data_out <= fq.pop_front();
            if (push_en) fq.push_back(push_val);
        end
        empty <= (fq.size() == 0);
    end

    // Monitor sampled mid-cycle.
    always @(negedge rdclk) begin
        cyc++;
        if (!rd_rst) begin
            if (pop) begin
                pops++;
                pop_cyc.push_back(cyc);
            end
            if (pop && empty) begin
                pe_errs++;
                $display("FAIL pop_while_empty: pop=1 empty=1 cycle %0d, required pop=0", cyc);
            end
            if (done) done_cnt++;
            if (m_valid && m_ready) got.push_back(m_data);
            if (pv && !pr && (!m_valid || m_data != pd)) begin
                stab_errs++;
                $display("FAIL stability: valid=%0d data=%02h, required valid=1 data=%02h",
                         m_valid, m_data, pd);
            end
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
        end else begin
            pv = 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rdclk);
            #1;
        end
    endtask

    task automatic flush_fifo();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        expq.delete();
        pend.delete();
    endtask

    task automatic preload(input logic [7:0] w);
        expq.push_back(w);
        push_en  = 1'b1;
        push_val = w;
        tick(1);
        push_en  = 1'b0;
    endtask

    task automatic add_pend(input logic [7:0] w);
        expq.push_back(w);
        pend.push_back(w);
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick(1);
        start = 1'b0;
    endtask

    // Run until done or budget; n is the cycle index (start cycle = 0).
    task automatic run(input int budget, input int rmode, input int pprob,
                       output int ok, output int n);
        ok = 0;
        n  = 0;
        while (ok == 0 && n < budget) begin
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = ((n % 2) == 0);
            endcase
            if (pend.size() > 0 && $urandom_range(0, 99) < pprob) begin
                push_en  = 1'b1;
                push_val = pend.pop_front();
            end else begin
                push_en = 1'b0;
            end
            @(negedge rdclk);
            n++;
            if (done) ok = 1;
            @(posedge rdclk);
            #1;
        end
        push_en = 1'b0;
    endtask

    task automatic cmp_burst(input string name, input int base, input int n);
        int bad;
        bad = 0;
        check({name, "_count"}, got.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i >= got.size() || i >= expq.size()) bad++;
            else if (got[base + i] != expq[i]) bad++;
        end
        check({name, "_order_bad"}, bad, 0);
    endtask

    initial begin
        int ok;
        int n;
        int b;
        int d0;
        int p0;
        int pc;
        int l;
        int k;

        vecs[0] = '{5, 'h10, 0, 5, 'h14};
        vecs[1] = '{1, 'h40, 0, 1, 'h40};
        vecs[2] = '{7, 'h60, 2, 7, 'h66};
        vecs[3] = '{3, 'hF0, 1, 3, 'hF2};

        rd_rst   = 1'b1;
        start    = 1'b0;
        len      = 8'd0;
        m_ready  = 1'b0;
        push_en  = 1'b0;
        flush    = 1'b0;
        push_val = 8'h00;

        tick(2);
        check("rst_pop", pop, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_count", rd_count, 0);
        rd_rst = 1'b0;
        tick(1);

        // Table-driven bursts.
        for (int v = 0; v < 4; v++) begin
            flush_fifo();
            for (int i = 0; i < vecs[v].len; i++) preload(8'(vecs[v].base + i));
            b  = got.size();
            d0 = done_cnt;
            pc = pop_cyc.size();
            do_start(8'(vecs[v].len));
            run(300, vecs[v].rmode, 100, ok, n);
            tick(2);
            check($sformatf("vec%0d_done", v), ok, 1);
            cmp_burst($sformatf("vec%0d", v), b, vecs[v].exp_cnt);
            if (got.size() >= b + vecs[v].len)
                check($sformatf("vec%0d_last", v), got[b + vecs[v].len - 1], vecs[v].exp_last);
            else
                check($sformatf("vec%0d_last_missing", v), got.size(), b + vecs[v].len);
            check($sformatf("vec%0d_rd_count", v), rd_count, vecs[v].exp_cnt);
            check($sformatf("vec%0d_done_pulses", v), done_cnt - d0, 1);
            check($sformatf("vec%0d_busy_after", v), busy, 0);
            if (vecs[v].rmode == 0) begin
                if (pop_cyc.size() >= pc + vecs[v].len)
                    check($sformatf("vec%0d_pop_span", v),
                          pop_cyc[pc + vecs[v].len - 1] - pop_cyc[pc], vecs[v].len - 1);
                else
                    check($sformatf("vec%0d_pop_num", v), pop_cyc.size(), pc + vecs[v].len);
            end
        end

        // Backpressure: three words claimed, head holds.
        flush_fifo();
        for (int i = 0; i < 6; i++) preload(8'(8'h10 + i));
        m_ready = 1'b0;
        b  = got.size();
        d0 = done_cnt;
        p0 = pops;
        do_start(8'd6);
        tick(10);
        check("bp_pops_stalled", pops - p0, 3);
        check("bp_m_valid", m_valid, 1);
        check("bp_m_data", m_data, 8'h10);
        check("bp_busy", busy, 1);
        run(100, 0, 100, ok, n);
        tick(2);
        check("bp_done", ok, 1);
        cmp_burst("bp", b, 6);
        check("bp_rd_count", rd_count, 6);
        check("bp_done_pulses", done_cnt - d0, 1);

        // Underflow stall: FIFO runs dry mid-burst.
        flush_fifo();
        preload(8'h30);
        preload(8'h31);
        m_ready = 1'b1;
        b  = got.size();
        d0 = done_cnt;
        p0 = pops;
        do_start(8'd4);
        tick(8);
        check("uf_pops", pops - p0, 2);
        check("uf_pop_now", pop, 0);
        check("uf_empty", empty, 1);
        check("uf_busy", busy, 1);
        check("uf_rd_count_mid", rd_count, 2);
        check("uf_no_done", done_cnt - d0, 0);
        add_pend(8'h32);
        add_pend(8'h33);
        run(100, 0, 100, ok, n);
        tick(2);
        check("uf_done", ok, 1);
        cmp_burst("uf", b, 4);
        check("uf_rd_count", rd_count, 4);
        check("uf_done_pulses", done_cnt - d0, 1);

        // Zero length.
        flush_fifo();
        p0 = pops;
        d0 = done_cnt;
        do_start(8'd0);
        run(6, 0, 100, ok, n);
        check("zl_done", ok, 1);
        check("zl_done_cycle", n, 1);
        check("zl_pops", pops - p0, 0);
        check("zl_busy_after", busy, 0);

        // Start during an active burst is ignored.
        flush_fifo();
        for (int i = 0; i < 3; i++) preload(8'(8'h70 + i));
        m_ready = 1'b0;
        b  = got.size();
        d0 = done_cnt;
        p0 = pops;
        do_start(8'd3);
        tick(2);
        do_start(8'd7);
        tick(2);
        run(100, 0, 100, ok, n);
        tick(3);
        check("sb_done", ok, 1);
        cmp_burst("sb", b, 3);
        check("sb_rd_count", rd_count, 3);
        check("sb_pops", pops - p0, 3);
        check("sb_done_pulses", done_cnt - d0, 1);
        check("sb_busy_after", busy, 0);

        // Reset mid-burst.
        flush_fifo();
        for (int i = 0; i < 8; i++) preload(8'(8'hA0 + i));
        m_ready = 1'b1;
        d0 = done_cnt;
        do_start(8'd8);
        tick(2);
        check("rm_pre_m_valid", m_valid, 1);
        #1;
        rd_rst = 1'b1;
        #1;
        check("rm_pop", pop, 0);
        check("rm_m_valid", m_valid, 0);
        check("rm_m_data", m_data, 0);
        check("rm_busy", busy, 0);
        check("rm_done", done, 0);
        check("rm_rd_count", rd_count, 0);
        @(posedge rdclk);
        #1;
        flush_fifo();
        rd_rst = 1'b0;
        tick(1);
        check("rm_no_done", done_cnt - d0, 0);
        preload(8'h5A);
        preload(8'h5B);
        b  = got.size();
        d0 = done_cnt;
        do_start(8'd2);
        run(50, 0, 100, ok, n);
        tick(2);
        check("rm2_done", ok, 1);
        cmp_burst("rm2", b, 2);
        check("rm2_rd_count", rd_count, 2);
        check("rm2_done_pulses", done_cnt - d0, 1);

        // Throughput: 255 words with the FIFO never running dry.
        flush_fifo();
        for (int i = 0; i < 4; i++) preload(8'(i));
        for (int i = 4; i < 255; i++) add_pend(8'(i));
        b  = got.size();
        pc = pop_cyc.size();
        do_start(8'd255);
        run(400, 0, 100, ok, n);
        tick(2);
        check("tp_done", ok, 1);
        check("tp_latency_ok", (n >= 256 && n <= 258) ? 1 : 0, 1);
        if (ok == 0 || n < 256 || n > 258)
            $display("  throughput latency %0d cycles, window 256..258", n);
        cmp_burst("tp", b, 255);
        check("tp_rd_count", rd_count, 255);
        if (pop_cyc.size() >= pc + 255)
            check("tp_pop_span", pop_cyc[pc + 254] - pop_cyc[pc], 254);
        else
            check("tp_pop_num", pop_cyc.size(), pc + 255);

        // Random bursts against the ordered-stream model.
        for (int r = 0; r < 20; r++) begin
            flush_fifo();
            l = $urandom_range(1, 24);
            k = $urandom_range(0, l);
            for (int i = 0; i < k; i++) preload(8'($urandom));
            for (int i = k; i < l; i++) add_pend(8'($urandom));
            b  = got.size();
            d0 = done_cnt;
            p0 = pops;
            do_start(8'(l));
            run(2000, 1, 50, ok, n);
            tick(2);
            check($sformatf("rnd%0d_done", r), ok, 1);
            cmp_burst($sformatf("rnd%0d", r), b, l);
            check($sformatf("rnd%0d_rd_count", r), rd_count, l);
            check($sformatf("rnd%0d_pops", r), pops - p0, l);
            check($sformatf("rnd%0d_done_pulses", r), done_cnt - d0, 1);
        end

        check("pop_while_empty_total", pe_errs, 0);
        check("stability_total", stab_errs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_drainer.md
Name: fifo_rd_drainer

Overview:
Read-side consumer of the aFIFO, clocked in the read domain. It is the counterpart of the writer/driver that pushes into the FIFO. On a start request it pops exactly `len` words, absorbing the FIFO's one-cycle read latency. Words are delivered on a valid/ready stream through a small skid buffer, and `done` pulses when the last word has been accepted downstream. It sits between the FIFO read port (pop/data_out/empty) and the downstream checker or consumer.

Parameters:
- DATA_W, 8, width of FIFO read data; matches valores_t in fifo_pkg.
- CNT_W, 8, width of the length and count fields; maximum burst is 2^CNT_W-1 words.
- BUF_DEPTH, 3, output skid buffer entries; must be ≥3 for 1 word/cycle throughput.

Ports:
- rdclk, input, 1, read-domain clock; all logic is on its rising edge.
- rd_rst, input, 1, asynchronous, active-high reset.
- start, input, 1, one-cycle request to begin a burst; sampled only in IDLE.
- len, input, CNT_W, burst length, captured when start is accepted.
- empty, input, 1, FIFO empty flag in the read domain.
- data_out, input, DATA_W, FIFO read data; valid in the cycle after pop.
- pop, output, 1, FIFO read strobe (pop_t).
- m_valid, output, 1, downstream word valid.
- m_data, output, DATA_W, downstream word.
- m_ready, input, 1, downstream accept.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse at burst completion.
- rd_count, output, CNT_W, words accepted downstream in the current or last burst.

Behaviour:
- Reset values: pop=0, m_valid=0, m_data=0, busy=0, done=0, rd_count=0. State=IDLE; issued count, in-flight flag and buffer occupancy all 0.
- Asserting rd_rst mid-burst aborts the burst immediately. Any word in flight or buffered is discarded. No done pulse is produced.
- FSM IDLE:
  - start=1 and len≠0: capture len, clear rd_count and issued count, go to READ.
  - start=1 and len=0: go to DONE.
  - start=0: stay in IDLE.
- FSM READ:
  - pop = !empty && (issued<len) && (occ+inflight < BUF_DEPTH). This is combinational from registers and empty, with no path from m_ready.
  - Each pop increments issued.
  - When issued reaches len on a pop, go to DRAIN.
- FSM DRAIN: pop=0. Wait until rd_count==len, i.e. the last word has been accepted, then go to DONE.
- FSM DONE: done=1 for exactly one cycle, then go to IDLE. busy is still 1 in DONE.
- Read latency:
  - A pop in cycle t sets inflight.
  - data_out is written into the skid buffer at the edge ending cycle t+1.
  - The word is visible as m_valid/m_data in cycle t+2 at the earliest.
- Skid buffer:
  - Ordered, BUF_DEPTH entries; m_data is the head entry.
  - m_valid = occ≠0.
  - A transfer happens when m_valid && m_ready. It pops the head and increments rd_count.
  - A simultaneous write and read in the same cycle leaves occ unchanged.
- Flow-control invariants:
  - occ+inflight never exceeds BUF_DEPTH.
  - The buffer never overflows, and no word is ever dropped.
- m_valid/m_data stability: once m_valid=1, m_valid and m_data hold until m_ready=1.
- Empty boundary: pop is never asserted while empty=1. If the FIFO runs dry mid-burst, the block stays in READ and waits indefinitely.
- start while busy is ignored and has no effect on the current burst.
- rd_count saturates at len and holds its value after done until the next accepted start.
- Throughput: with the FIFO non-empty and m_ready held at 1, the block sustains 1 word/cycle after the initial 2-cycle latency.

Decomposition:
- fifo_pkg holds:
  - valores_t, push_t, pop_t (existing types);
  - drn_state_t enum {IDLE, READ, DRAIN, DONE};
  - DATA_W and CNT_W defaults.
- Sub-module fifo_rd_skid_buf: BUF_DEPTH-entry register FIFO with wr_en/wr_data, rd_en, head data, occ output, and the same rdclk/rd_rst.

Test Plan:
- Single burst: FIFO preloaded with 0x10..0x14, len=5, m_ready=1 → five pops on consecutive cycles. m_data sequence is 0x10,0x11,0x12,0x13,0x14. done pulses once, and rd_count=5.
- Backpressure: len=6, FIFO full, m_ready low for 10 cycles → pop stops after 3 words and m_data holds 0x10. After m_ready rises, all 6 words arrive in order with no loss or duplication.
- Underflow stall: len=4, only 2 words available → 2 pops, then pop=0 while empty=1 and busy stays 1. Pushing 2 more words resumes the burst, and done pulses after the 4th accept.
- Zero length and re-start: start with len=0 → done in the cycle after start, with no pop. A start asserted during an active burst is ignored, and rd_count is unaffected.
- Reset mid-burst: assert rd_rst during cycle 3 of an 8-word burst → all outputs 0 asynchronously and state=IDLE. A new start with len=2 then completes normally.
- Throughput check: len=255, FIFO never empty, m_ready=1 → done arrives 257±1 cycles after start, and pop is never asserted while empty=1 (checked by assertion).
